// File: rtl/alu_pkg.sv
// Shared definitions for the ALU / iterative multiply-divide unit:
// op-code constants, FSM state encoding, default datapath width.
package alu_pkg;

    localparam int DEF_WIDTH = 32;

    localparam logic [3:0] OP_AND   = 4'd0;
    localparam logic [3:0] OP_OR    = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_SUB   = 4'd6;
    localparam logic [3:0] OP_SLT   = 4'd7;
    localparam logic [3:0] OP_MULT  = 4'd8;
    localparam logic [3:0] OP_MULTU = 4'd9;
    localparam logic [3:0] OP_DIV   = 4'd10;
    localparam logic [3:0] OP_DIVU  = 4'd11;
    localparam logic [3:0] OP_NOR   = 4'd12;
    localparam logic [3:0] OP_MFHI  = 4'd13;
    localparam logic [3:0] OP_MFLO  = 4'd14;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Ops 8..11 share the 4'b10xx pattern; 10/11 are the divides.
    function automatic logic is_muldiv(input logic [3:0] op);
        return op[3:2] == 2'b10;
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return op[3:1] == 3'b101;
    endfunction

endpackage

// File: rtl/alu_multdiv_core.sv
// Iterative multiply / restoring-divide datapath with step counter.
// Ports: load (capture operands/op), step (one iteration), a/b operands,
// op code; last flags the final step, res_hi/res_lo give the result that
// the final step produces (valid while last is high).
// Macro ALU_SIGNED_MULDIV_EN: ops 8/10 take magnitudes and fix sign at end.
module alu_multdiv_core
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    // Mult: {partial product, multiplier}; div: {remainder, quotient}.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               div_q, div_d;

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH+1:0]   diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;

`ifdef ALU_SIGNED_MULDIV_EN
    logic negp_q, negp_d;
    logic negr_q, negr_d;
    logic sgn, sa, sb;

    // A zero divisor keeps the raw dividend so the remainder equals it.
    always_comb begin
        sgn   = (op == OP_MULT) || (op == OP_DIV);
        sa    = sgn && a[WIDTH-1] && !(is_div(op) && (b == '0));
        sb    = sgn && b[WIDTH-1];
        a_mag = sa ? -a : a;
        b_mag = sb ? -b : b;
    end
`else
    assign a_mag = a;
    assign b_mag = b;
`endif

    always_comb begin
        sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
               + (acc_q[0] ? {1'b0, b_q} : '0);
        rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
        diff   = {1'b0, rem_sh} - {2'b0, b_q};
        acc_d  = acc_q;
        b_d    = b_q;
        cnt_d  = cnt_q;
        div_d  = div_q;
`ifdef ALU_SIGNED_MULDIV_EN
        negp_d = negp_q;
        negr_d = negr_q;
`endif
        if (load) begin
            acc_d  = {{WIDTH{1'b0}}, a_mag};
            b_d    = b_mag;
            cnt_d  = '0;
            div_d  = is_div(op);
`ifdef ALU_SIGNED_MULDIV_EN
            negp_d = sa ^ sb;
            negr_d = sa && is_div(op);
`endif
        end else if (step) begin
            cnt_d = cnt_q + 1'b1;
            if (div_q) begin
                if (diff[WIDTH+1])
                    acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                else
                    acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = {sum, acc_q[WIDTH-1:1]};
            end
        end
    end

    always_comb begin
        prod = acc_d;
        quo  = acc_d[WIDTH-1:0];
        rem  = acc_d[2*WIDTH-1:WIDTH];
`ifdef ALU_SIGNED_MULDIV_EN
        if (negp_q) begin
            prod = -acc_d;
            quo  = -acc_d[WIDTH-1:0];
        end
        if (negr_q)
            rem = -acc_d[2*WIDTH-1:WIDTH];
`endif
        if (div_q) begin
            res_hi = rem;
            res_lo = quo;
        end else begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end
    end

    assign last = step && (cnt_q == LAST_CNT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_q  <= '0;
            b_q    <= '0;
            cnt_q  <= '0;
            div_q  <= 1'b0;
`ifdef ALU_SIGNED_MULDIV_EN
            negp_q <= 1'b0;
            negr_q <= 1'b0;
`endif
        end else begin
            acc_q  <= acc_d;
            b_q    <= b_d;
            cnt_q  <= cnt_d;
            div_q  <= div_d;
`ifdef ALU_SIGNED_MULDIV_EN
            negp_q <= negp_d;
            negr_q <= negr_d;
`endif
        end
    end

endmodule

// File: rtl/alu_multdiv.sv
// ALU with iterative multiply/divide and HI/LO registers.
// Ports: clock, reset (async, active high), start, dado_1/dado_2 operands,
// ALUControl op code; busy, done pulse, registered ALUResult/zero, hi, lo.
// Macro ALU_SIGNED_MULDIV_EN: MULT/DIV signed (else same as MULTU/DIVU).
module alu_multdiv
    import alu_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int DIV_ZERO_FAST = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dado_1,
    input  logic [WIDTH-1:0] dado_2,
    input  logic [3:0]       ALUControl,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ALUResult,
    output logic             zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             load, step, core_last;
    logic [WIDTH-1:0] core_hi, core_lo;
    logic [WIDTH-1:0] alu_res;
    logic             div_zero_fast;

    alu_multdiv_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clock  (clock),
        .reset  (reset),
        .load   (load),
        .step   (step),
        .op     (ALUControl),
        .a      (dado_1),
        .b      (dado_2),
        .last   (core_last),
        .res_hi (core_hi),
        .res_lo (core_lo)
    );

    always_comb begin
        case (ALUControl)
            OP_AND:  alu_res = dado_1 & dado_2;
            OP_OR:   alu_res = dado_1 | dado_2;
            OP_ADD:  alu_res = dado_1 + dado_2;
            OP_SUB:  alu_res = dado_1 - dado_2;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}},
                                $signed(dado_1) < $signed(dado_2)};
            OP_NOR:  alu_res = ~(dado_1 | dado_2);
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
            default: alu_res = '0;
        endcase
    end

    assign div_zero_fast = (DIV_ZERO_FAST != 0)
                         && is_div(ALUControl)
                         && (dado_2 == '0);
    assign step = (state_q == S_CALC);

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        load    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (is_muldiv(ALUControl) && !div_zero_fast) begin
                        load    = 1'b1;
                        state_d = S_CALC;
                    end else if (div_zero_fast) begin
                        hi_d    = dado_1;
                        lo_d    = '1;
                        res_d   = '1;
                        state_d = S_DONE;
                    end else begin
                        res_d   = alu_res;
                        state_d = S_DONE;
                    end
                end
            end
            S_CALC: begin
                if (core_last) begin
                    hi_d    = core_hi;
                    lo_d    = core_lo;
                    res_d   = core_lo;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        zero_d = (res_d == '0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            res_q   <= '0;
            zero_q  <= 1'b1;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign ALUResult = res_q;
    assign zero      = zero_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_alu_multdiv.sv
// Self-checking bench for alu_multdiv: behavioural model plus
// per-cycle compare, directed cases and randomized traffic.
module tb_alu_multdiv;

    localparam int W = 32;

`ifdef ALU_SIGNED_MULDIV_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [3:0]    ctl   = 4'd0;
    logic [W-1:0]  d1    = '0;
    logic [W-1:0]  d2    = '0;
    logic          busy, done, zero;
    logic [W-1:0]  res, hi, lo;

    int n_checks = 0;
    int n_err    = 0;

    alu_multdiv #(
        .WIDTH         (W),
        .DIV_ZERO_FAST (1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .dado_1     (d1),
        .dado_2     (d2),
        .ALUControl (ctl),
        .busy       (busy),
        .done       (done),
        .ALUResult  (res),
        .zero       (zero),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Architectural result of one op from its arithmetic definition.
    task automatic model_op(input logic [3:0] op,
                            input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] h, input logic [W-1:0] l,
                            output logic [W-1:0] r,
                            output logic [W-1:0] nh, output logic [W-1:0] nl,
                            output int lat);
        longint      sa, sb, q, rm;
        logic [63:0] p;
        bit          s;
        nh  = h;
        nl  = l;
        lat = 1;
        r   = '0;
        s   = SGN && (op == 4'd8 || op == 4'd10);
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        case (op)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2:  r = a + b;
            4'd6:  r = a - b;
            4'd7:  r = (sa < sb) ? 32'd1 : 32'd0;
            4'd12: r = ~(a | b);
            4'd13: r = h;
            4'd14: r = l;
            4'd8, 4'd9: begin
                if (s) p = sa * sb;
                else   p = {32'b0, a} * {32'b0, b};
                nh  = p[63:32];
                nl  = p[31:0];
                r   = nl;
                lat = W + 1;
            end
            4'd10, 4'd11: begin
                if (b == 0) begin
                    nl  = '1;
                    nh  = a;
                    lat = 1;
                end else begin
                    lat = W + 1;
                    if (s) begin
                        q  = sa / sb;
                        rm = sa % sb;
                        nl = q[31:0];
                        nh = rm[31:0];
                    end else begin
                        nl = a / b;
                        nh = a % b;
                    end
                end
                r = nl;
            end
            default: r = '0;
        endcase
    endtask

    // Visible-state model: results appear when the op's latency elapses.
    logic [W-1:0] m_res = '0, m_hi = '0, m_lo = '0;
    logic         m_zero = 1'b1;
    int           left = 0;
    logic [W-1:0] p_res, p_hi, p_lo;
    int           p_lat;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            left   = 0;
            m_res  = '0;
            m_zero = 1'b1;
            m_hi   = '0;
            m_lo   = '0;
        end else begin
            if (left == 0) begin
                if (start) begin
                    model_op(ctl, d1, d2, m_hi, m_lo,
                             p_res, p_hi, p_lo, p_lat);
                    left = p_lat;
                end
            end else begin
                left--;
            end
            if (left == 1) begin
                m_res  = p_res;
                m_zero = (p_res == 0);
                m_hi   = p_hi;
                m_lo   = p_lo;
            end
        end
    end

    always @(negedge clock) begin
        chk("busy",   busy, left > 0);
        chk("done",   done, left == 1);
        chk("result", res,  m_res);
        chk("zero",   zero, m_zero);
        chk("hi",     hi,   m_hi);
        chk("lo",     lo,   m_lo);
    end

    function automatic logic [W-1:0] rv();
        case ($urandom % 6)
            0:       return '0;
            1:       return W'($urandom % 16);
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            default: return W'($urandom);
        endcase
    endfunction

    function automatic logic [3:0] rop();
        int k;
        k = int'($urandom % 16);
        if (k < 8) return 4'(8 + k % 4);
        return 4'($urandom);
    endfunction

    // Issue one op once idle, optionally poke an ADD start at cycle intr.
    task automatic run(input logic [3:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input int intr, output int lat,
                       output logic [W-1:0] r, output logic [W-1:0] h,
                       output logic [W-1:0] l, output logic z);
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (busy) chk("idle_timeout", busy, 0);
        start = 1'b1;
        ctl   = op;
        d1    = a;
        d2    = b;
        lat   = 0;
        do begin
            @(negedge clock);
            lat++;
            start = (lat == intr);
            ctl   = (lat == intr) ? 4'd2 : 4'($urandom);
            d1    = W'($urandom);
            d2    = W'($urandom);
        end while (!done && lat < 60);
        chk("done_timeout", done, 1);
        r = res;
        h = hi;
        l = lo;
        z = zero;
    endtask

    initial begin
        int           lat, pulses, n;
        logic [W-1:0] r, h, l;
        logic         z;

        #1 reset = 1'b1;
        repeat (2) @(negedge clock);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_res",  res,  0);
        chk("rst_zero", zero, 1);
        chk("rst_hi",   hi,   0);
        chk("rst_lo",   lo,   0);

        model_op(4'd2, 3, 3, 0, 0, r, h, l, lat);
        chk("pin_add", r, 6);
        model_op(4'd9, 32'hFFFF_FFFF, 2, 0, 0, r, h, l, lat);
        chk("pin_multu_hi", h, 32'h1);
        chk("pin_multu_lo", l, 32'hFFFF_FFFE);
        chk("pin_multu_lat", lat, 33);
        model_op(4'd11, 7, 2, 0, 0, r, h, l, lat);
        chk("pin_divu_q", l, 3);
        chk("pin_divu_r", h, 1);
        model_op(4'd11, 5, 0, 0, 0, r, h, l, lat);
        chk("pin_dz_lo", l, 32'hFFFF_FFFF);
        chk("pin_dz_lat", lat, 1);
        model_op(4'd7, 32'hFFFF_FFFF, 1, 0, 0, r, h, l, lat);
        chk("pin_slt", r, 1);
        model_op(4'd15, 9, 9, 5, 7, r, h, l, lat);
        chk("pin_unk", {r, h}, {32'h0, 32'h5});
`ifdef ALU_SIGNED_MULDIV_EN
        model_op(4'd10, 32'hFFFF_FFF9, 2, 0, 0, r, h, l, lat);
        chk("pin_div_q", l, 32'hFFFF_FFFD);
        chk("pin_div_r", h, 32'hFFFF_FFFF);
`endif

        reset = 1'b0;
        run(4'd2, 3, 3, 0, lat, r, h, l, z);
        chk("add_res", r, 6);
        chk("add_zero", z, 0);
        chk("add_lat", lat, 1);
        run(4'd6, 3, 3, 0, lat, r, h, l, z);
        chk("sub_res", r, 0);
        chk("sub_zero", z, 1);

        run(4'd8, 32'hFFFF_FFFF, 2, 0, lat, r, h, l, z);
        chk("mult_lat", lat, 33);
        chk("mult_lo", l, 32'hFFFF_FFFE);
        chk("mult_hi", h, SGN ? 32'hFFFF_FFFF : 32'h1);
        run(4'd9, 32'hFFFF_FFFF, 2, 0, lat, r, h, l, z);
        chk("multu_hi", h, 32'h1);
        chk("multu_lo", l, 32'hFFFF_FFFE);

        run(4'd10, 32'hFFFF_FFF9, 2, 0, lat, r, h, l, z);
        chk("div_lo", l, SGN ? 32'hFFFF_FFFD : 32'h7FFF_FFFC);
        chk("div_hi", h, SGN ? 32'hFFFF_FFFF : 32'h1);
        run(4'd11, 7, 2, 0, lat, r, h, l, z);
        chk("divu_lo", l, 3);
        chk("divu_hi", h, 1);
        run(4'd13, 0, 0, 0, lat, r, h, l, z);
        chk("mfhi_res", r, 1);
        chk("mfhi_lat", lat, 1);

        run(4'd11, 5, 0, 0, lat, r, h, l, z);
        chk("dz_lo", l, 32'hFFFF_FFFF);
        chk("dz_hi", h, 5);
        chk("dz_lat", lat, 1);

        run(4'd15, 1, 1, 0, lat, r, h, l, z);
        chk("unk_res", r, 0);
        chk("unk_zero", z, 1);
        chk("unk_hilo", {h, l}, {32'h5, 32'hFFFF_FFFF});
        chk("unk_lat", lat, 1);

        run(4'd9, 7, 6, 5, lat, r, h, l, z);
        chk("intr_lo", l, 42);
        chk("intr_hi", h, 0);
        chk("intr_lat", lat, 33);

        @(negedge clock);
        start = 1'b1;
        ctl   = 4'd8;
        d1    = 32'h1234_5678;
        d2    = 32'h9ABC_DEF0;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_hilo", {hi, lo}, 64'h0);
        chk("mid_rst_res", {zero, res}, {1'b1, 32'h0});
        @(negedge clock);
        reset  = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(negedge clock);
            if (done) pulses++;
        end
        chk("mid_rst_no_done", pulses, 0);

        repeat (3000) begin
            @(negedge clock);
            start = ($urandom % 3 == 0);
            ctl   = rop();
            d1    = rv();
            d2    = rv();
        end
        @(negedge clock);
        start = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("final_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_multdiv.md
ALU_MULTDIV -- requirements
Module: alu_multdiv

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (min 8, even).
REQ-002 SHALL have parameter DIV_ZERO_FAST, default 1; 1 = divide-by-zero completes in 1 cycle, 0 = takes full WIDTH cycles.
REQ-003 clock  input  1  single clock, rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  operation request; sampled only in IDLE.
REQ-006 dado_1  input  WIDTH  operand A / dividend.
REQ-007 dado_2  input  WIDTH  operand B / divisor.
REQ-008 ALUControl  input  4  op code: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT, 8 MULT, 9 MULTU, 10 DIV, 11 DIVU, 12 NOR, 13 MFHI, 14 MFLO.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 done  output  1  one-cycle pulse; result valid.
REQ-011 ALUResult  output  WIDTH  registered result; held until next done.
REQ-012 zero  output  1  registered (ALUResult == 0), updated with ALUResult.
REQ-013 hi, lo  output  WIDTH each  HI/LO architectural registers.

Function
REQ-014 FSM states IDLE, CALC, DONE; IDLE->CALC on start with op 8-11 (non-zero divisor or DIV_ZERO_FAST=0); IDLE->DONE on start with any other op; CALC->DONE after exactly WIDTH cycles; DONE->IDLE unconditionally.
REQ-015 Operands and ALUControl SHALL be captured on the accepting edge; later input changes have no effect on the running op.
REQ-016 start while busy SHALL be ignored (no queuing).
REQ-017 Single-cycle ops: done high in cycle after acceptance (latency 1).
REQ-018 MULT/MULTU/DIV/DIVU: done high WIDTH+1 cycles after acceptance.
REQ-019 ADD/SUB wrap modulo 2^WIDTH; no overflow flag; SLT signed compare, result 1 or 0.
REQ-020 MULT/MULTU: {hi,lo} = 2*WIDTH-bit product; ALUResult = lo.
REQ-021 DIV/DIVU: lo = quotient, hi = remainder; signed quotient truncates toward zero, remainder takes sign of dividend; ALUResult = lo.
REQ-022 Divide by zero: lo = all ones, hi = dado_1; latency 1 if DIV_ZERO_FAST=1 else WIDTH+1.
REQ-023 MFHI/MFLO: ALUResult = hi/lo as held before the op; hi/lo unchanged.
REQ-024 hi/lo SHALL change only at completion of ops 8-11.
REQ-025 Unknown op codes: ALUResult = 0, zero = 1, latency 1, hi/lo unchanged.
REQ-026 Iterative datapath: one shift-add (mult) or restoring-subtract (div) step per CALC cycle.

Reset
REQ-027 reset SHALL force IDLE, busy=0, done=0, ALUResult=0, zero=1, hi=0, lo=0 immediately, including mid-CALC; partial result discarded.
REQ-028 First start SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-029 Macro ALU_SIGNED_MULDIV_EN: defined -> op 8/10 signed per REQ-020/021 (operand magnitudes processed, sign fixed up at completion, same latency).
REQ-030 Not defined -> op 8/10 behave identically to 9/11 (unsigned); no sign-fix logic synthesised.

Structure
REQ-031 Package alu_pkg SHALL hold op-code constants, FSM state encoding and default WIDTH.
REQ-032 Sub-module alu_multdiv_core SHALL contain the iterative mult/div datapath and step counter; top holds FSM, single-cycle ALU, hi/lo and output registers.

Verification (WIDTH=32)
REQ-033 ADD dado_1=3, dado_2=3 -> ALUResult=6, zero=0, done 1 cycle after start; then SUB 3,3 -> ALUResult=0, zero=1.
REQ-034 MULT 0xFFFFFFFF*2 with EN -> hi=0xFFFFFFFF, lo=0xFFFFFFFE, done at cycle 33; MULTU same operands -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-035 DIV -7/2 with EN -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/2 -> lo=3, hi=1; then MFHI -> ALUResult=1.
REQ-036 DIVU 5/0, DIV_ZERO_FAST=1 -> lo=0xFFFFFFFF, hi=5, done 1 cycle after start.
REQ-037 start during CALC with ADD -> ignored, MULT result unaffected; reset asserted 10 cycles into MULT -> busy=0, hi=lo=0 immediately, no done pulse.
REQ-038 ALUControl=15 -> ALUResult=0, zero=1, hi/lo unchanged, latency 1.
